// File: rtl/ysyx_22050550_wb_stage.sv
// ysyx_22050550 write-back stage: head register, wdata select, commit and bypass taps.
// Define YSYX_22050550_WB_SKID_EN to add a skid entry and a registered ready.
module ysyx_22050550_wb_stage #(
   parameter int XLEN = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            io_LSWB_valid,
   output logic            io_ReadyWB_ready,
   input  logic [XLEN-1:0] io_LSWB_pc,
   input  logic [XLEN-1:0] io_LSWB_NextPc,
   input  logic [31:0]     io_LSWB_inst,
   input  logic [4:0]      io_LSWB_wdaddr,
   input  logic            io_LSWB_wen,
   input  logic            io_LSWB_readflag,
   input  logic            io_LSWB_jalrflag,
   input  logic            io_LSWB_csrflag,
   input  logic            io_LSWB_ecallflag,
   input  logic            io_LSWB_mretflag,
   input  logic            io_LSWB_ebreak,
   input  logic            io_LSWB_SkipRef,
   input  logic [XLEN-1:0] io_LSWB_alures,
   input  logic [XLEN-1:0] io_LSWB_lsures,
   input  logic [XLEN-1:0] io_CSR_rdata,
   input  logic            io_stall,
   output logic            io_WB_wen,
   output logic [4:0]      io_WB_waddr,
   output logic [XLEN-1:0] io_WB_wdata,
   output logic            io_WB_byp_valid,
   output logic [4:0]      io_WB_byp_addr,
   output logic [XLEN-1:0] io_WB_byp_data,
   output logic            io_commit_valid,
   output logic [XLEN-1:0] io_commit_pc,
   output logic [XLEN-1:0] io_commit_nextpc,
   output logic [31:0]     io_commit_inst,
   output logic            io_commit_skipref,
   output logic            io_commit_ecall,
   output logic            io_commit_mret,
   output logic [XLEN-1:0] io_instret,
   output logic            io_halt
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] nextpc;
      logic [31:0]     inst;
      logic [4:0]      wdaddr;
      logic            wen;
      logic            readflag;
      logic            jalrflag;
      logic            csrflag;
      logic            ecall;
      logic            mret;
      logic            ebreak;
      logic            skipref;
      logic [XLEN-1:0] alures;
      logic [XLEN-1:0] lsures;
   } wb_ent_t;

   wb_ent_t         main_q;
   wb_ent_t         in_ent;
   logic            main_v;
   logic            halt_q;
   logic [XLEN-1:0] instret_q;
   logic            ready;
   logic            fire;
   logic            retire;
   logic            rd_ok;
   logic [XLEN-1:0] wdata;

   assign in_ent = '{
      pc:       io_LSWB_pc,
      nextpc:   io_LSWB_NextPc,
      inst:     io_LSWB_inst,
      wdaddr:   io_LSWB_wdaddr,
      wen:      io_LSWB_wen,
      readflag: io_LSWB_readflag,
      jalrflag: io_LSWB_jalrflag,
      csrflag:  io_LSWB_csrflag,
      ecall:    io_LSWB_ecallflag,
      mret:     io_LSWB_mretflag,
      ebreak:   io_LSWB_ebreak,
      skipref:  io_LSWB_SkipRef,
      alures:   io_LSWB_alures,
      lsures:   io_LSWB_lsures
   };

   assign retire = main_v & ~io_stall & ~halt_q;
   assign fire   = io_LSWB_valid & ready;

`ifdef YSYX_22050550_WB_SKID_EN
   wb_ent_t skid_q;
   logic    skid_v;
   logic    skid_v_n;
   logic    halt_n;
   logic    ready_q;

   assign ready    = ready_q;
   assign halt_n   = halt_q | (retire & main_q.ebreak);
   assign skid_v_n = retire ? (skid_v & fire)
                            : (skid_v | (fire & main_v));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         main_q  <= '0;
         main_v  <= 1'b0;
         skid_q  <= '0;
         skid_v  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         // skid always drains ahead of a new entry
         if (retire) begin
            if (skid_v)
               main_q <= skid_q;
            else if (fire)
               main_q <= in_ent;
            main_v <= skid_v | fire;
            if (skid_v & fire)
               skid_q <= in_ent;
         end else if (fire) begin
            if (main_v) begin
               skid_q <= in_ent;
            end else begin
               main_q <= in_ent;
               main_v <= 1'b1;
            end
         end
         skid_v  <= skid_v_n;
         ready_q <= ~skid_v_n & ~halt_n;
      end
   end
`else
   assign ready = ~halt_q & (~main_v | retire);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         main_q <= '0;
         main_v <= 1'b0;
      end else if (fire) begin
         main_q <= in_ent;
         main_v <= 1'b1;
      end else if (retire) begin
         main_v <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         halt_q    <= 1'b0;
         instret_q <= '0;
      end else if (retire) begin
         instret_q <= instret_q + 1'b1;
         if (main_q.ebreak)
            halt_q <= 1'b1;
      end
   end

   always_comb begin
      wdata = main_q.alures;
      if (main_q.csrflag)
         wdata = io_CSR_rdata;
      else if (main_q.readflag)
         wdata = main_q.lsures;
      else if (main_q.jalrflag)
         wdata = main_q.pc + XLEN'(4);
   end

   assign rd_ok = main_q.wen & (main_q.wdaddr != 5'd0);

   assign io_ReadyWB_ready  = ready;
   assign io_WB_wen         = retire & rd_ok;
   assign io_WB_waddr       = main_q.wdaddr;
   assign io_WB_wdata       = wdata;
   assign io_WB_byp_valid   = main_v & rd_ok;
   assign io_WB_byp_addr    = main_q.wdaddr;
   assign io_WB_byp_data    = wdata;
   assign io_commit_valid   = retire;
   assign io_commit_pc      = main_q.pc;
   assign io_commit_nextpc  = main_q.nextpc;
   assign io_commit_inst    = main_q.inst;
   assign io_commit_skipref = main_q.skipref;
   assign io_commit_ecall   = main_q.ecall;
   assign io_commit_mret    = main_q.mret;
   assign io_instret        = instret_q;
   assign io_halt           = halt_q;

endmodule
